sfifo_wrarb: RTL
================

// Module: sfifo_wrarb
// PURPOSE
//  Round-robin, packet-locked write arbiter sharing one sfifo write port among
//  NIN requesters. Each requester offers a valid/ready/last stream. The winner
//  holds the grant until its last beat is accepted. Each FIFO word is tagged
//  {last, source index, data} so the read side can demultiplex packets.
// PARAMETERS
//  NIN     4  number of requesters, 2..16; LGNIN = $clog2(NIN) (localparam)
//  BW      8  requester data width; FIFO word width FW = BW+LGNIN+1
// PORTS
//  i_clk      in   1        clock, all state on rising edge
//  i_reset_n  in   1        asynchronous, active-low reset
//  i_valid    in   NIN      per-requester beat valid
//  i_last     in   NIN      per-requester last beat of packet
//  i_data     in   NIN*BW   requester n data at [n*BW +: BW]
//  o_ready    out  NIN      per-requester beat accepted this cycle if valid
//  o_wr       out  1        FIFO write strobe (to sfifo i_wr)
//  o_data     out  FW       {last, src[LGNIN-1:0], data[BW-1:0]} (to sfifo i_data)
//  i_full     in   1        FIFO full (from sfifo o_full)
//  o_busy     out  1        a packet grant is held
//  o_grant    out  LGNIN    index of current/most recent grantee
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, o_grant=NIN-1, o_busy=0,
//    o_ready=0, o_wr=0. o_data is don't-care while o_wr=0.
//  - FSM states: IDLE and BURST.
//  - IDLE: if |i_valid, register the winner: the first n with i_valid[n],
//    searching o_grant+1, o_grant+2, ... modulo NIN. Go to BURST.
//    No beat transfers in IDLE (one-cycle arbitration bubble).
//  - BURST, g=o_grant:
//    o_ready = (!i_full) << g (one-hot or zero), combinational.
//    xfer = i_valid[g] && !i_full; o_wr = xfer.
//    o_data = {i_last[g], g, i_data[g*BW +: BW]}.
//    On xfer && i_last[g]: go to IDLE.
//  - o_busy = (state==BURST).
//  - The grantee dropping i_valid mid-packet does not release the grant. The
//    lock persists until the last beat; there is no timeout.
//  - Non-granted requesters always see o_ready=0. Their inputs are ignored.
//  - i_full=1 stalls the grantee: no o_wr, state and grant unchanged.
//  - o_wr is never asserted while i_full=1, so the sfifo never drops a write.
//  - Single-beat packet (last on its first beat): 1 beat in BURST, then IDLE.
//    Peak rate is 1 packet per 2 cycles.
//  - Wrap: the search from NIN-1 continues at 0. Index arithmetic is modulo
//    NIN, and NIN need not be a power of 2.
//  - Fairness: a continuously requesting n waits at most NIN-1 packets.
//  - i_valid/i_last/i_data must be held stable while valid && !ready (AXI-S
//    rule). The bench checks this as an input assumption.
//  - Reset asserted mid-packet: the grant is dropped immediately and the next
//    packet arbitration restarts from index 0. A packet cut by reset is
//    already partly in the FIFO. The system resets the FIFO in the same domain.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE=1'b0, BURST=1'b1).
//  - Shared package: function for FW from BW and NIN.
//  - One sub-module, rr_pick: combinational round-robin priority pick.
//    Inputs: request vector and last index. Outputs: winner index, any.
//  - Remaining logic: the FSM plus the output mux, in this file.
// TESTING
//  - Single source: NIN=4, req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd)
//    -> o_wr 3 cycles after 1 bubble; o_data=
//    {0,2,A1},{0,2,A2},{1,2,A3}; o_busy falls after the last beat.
//  - Round-robin: all 4 requesters hold 1-beat packets continuously from reset
//    -> grant order 0,1,2,3,0; one word per 2 cycles.
//  - Packet lock: req 1 mid-packet drops i_valid for 3 cycles while req 3 is
//    valid -> grant stays 1, no o_wr, then req 1 resumes and finishes first.
//  - Backpressure: i_full=1 for 5 cycles mid-burst -> o_ready=0, o_wr=0, and
//    data is held. After release, beats resume in order with no loss or repeat.
//  - Async reset mid-burst: drop i_reset_n between edges -> o_busy, o_ready
//    and o_wr go to 0 immediately. After release, the first grant is the
//    lowest valid index.
//  - Scoreboard: random traffic into a real sfifo (LGFLEN=4) -> per-source
//    order preserved; no packet interleaved; FIFO never overflows.

Source files
------------

// File: rtl/sfifo_wrarb_pkg.sv
//------------------------------------------------------------------------------
// Module   : sfifo_wrarb_pkg
// Brief    : Shared FSM encoding and FIFO word-width helper for sfifo_wrarb.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sfifo_wrarb_pkg;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_BURST = 1'b1;

  // FIFO word is {last, source index, data}
  function automatic int fifo_width(input int bw, input int nin);
    return bw + $clog2(nin) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfifo_wrarb_if.sv
//------------------------------------------------------------------------------
// Module   : sfifo_wrarb_if
// Brief    : Requester streams, FIFO write port and status of the write arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sfifo_wrarb_if #(
  parameter int NIN = 4,
  parameter int BW  = 8
);
  import sfifo_wrarb_pkg::*;

  localparam int c_LGNIN = $clog2(NIN);
  localparam int c_FW    = fifo_width(BW, NIN);

  logic [NIN-1:0]     i_valid;
  logic [NIN-1:0]     i_last;
  logic [NIN*BW-1:0]  i_data;
  logic [NIN-1:0]     o_ready;
  logic               o_wr;
  logic [c_FW-1:0]    o_data;
  logic               i_full;
  logic               o_busy;
  logic [c_LGNIN-1:0] o_grant;

  // Arbiter side
  modport slave (
    input  i_valid, i_last, i_data, i_full,
    output o_ready, o_wr, o_data, o_busy, o_grant
  );

  // Requester / FIFO side
  modport master (
    output i_valid, i_last, i_data, i_full,
    input  o_ready, o_wr, o_data, o_busy, o_grant
  );

endinterface

`default_nettype wire

// File: rtl/sfifo_wrarb_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : sfifo_wrarb_rr_pick
// Brief    : Combinational round-robin pick starting one past the previous index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sfifo_wrarb_rr_pick #(
  parameter int NIN   = 4,
  parameter int LGNIN = 2
) (
  input  wire logic [NIN-1:0]   i_req,
  input  wire logic [LGNIN-1:0] i_prev,
  output logic      [LGNIN-1:0] o_win,
  output logic                  o_any
);

  // Modulo-NIN add; NIN need not be a power of two
  function automatic logic [LGNIN-1:0] wrap_add(input logic [LGNIN-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NIN) s = s - NIN;
    return LGNIN'(s);
  endfunction

  // Scan farthest-first so the nearest requester overwrites and wins
  always_comb begin
    o_win = i_prev;
    for (int k = NIN; k >= 1; k--) begin
      if (i_req[wrap_add(i_prev, k)]) o_win = wrap_add(i_prev, k);
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/sfifo_wrarb.sv
//------------------------------------------------------------------------------
// Module   : sfifo_wrarb
// Brief    : Round-robin, packet-locked write arbiter in front of one sfifo port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sfifo_wrarb
  import sfifo_wrarb_pkg::*;
#(
  parameter int NIN = 4,
  parameter int BW  = 8
) (
  input  wire logic    i_clk,
  input  wire logic    i_reset_n,
  sfifo_wrarb_if.slave bus
);

  localparam int c_LGNIN = $clog2(NIN);

  logic [0:0]       r_state;
  logic [c_LGNIN-1:0] r_grant;
  logic [c_LGNIN-1:0] w_pick;
  logic               w_any;
  logic [BW-1:0]      w_lane [NIN];
  logic [BW-1:0]      w_sel_data;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_burst;
  logic               w_xfer;

  sfifo_wrarb_rr_pick #(
    .NIN   (NIN),
    .LGNIN (c_LGNIN)
  ) u_pick (
    .i_req  (bus.i_valid),
    .i_prev (r_grant),
    .o_win  (w_pick),
    .o_any  (w_any)
  );

  for (genvar n = 0; n < NIN; n++) begin : g_lane
    assign w_lane[n] = bus.i_data[n*BW +: BW];
  end

  assign w_sel_data  = w_lane[r_grant];
  assign w_sel_valid = bus.i_valid[r_grant];
  assign w_sel_last  = bus.i_last[r_grant];
  assign w_burst     = (r_state == c_BURST);
  assign w_xfer      = w_burst && w_sel_valid && !bus.i_full;

  // Reset leaves the grant at NIN-1 so the first search starts at index 0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= c_IDLE;
      r_grant <= c_LGNIN'(NIN-1);
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= c_BURST;
          end
        end
        c_BURST: begin
          if (w_xfer && w_sel_last) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.o_ready = (w_burst && !bus.i_full) ? ({{(NIN-1){1'b0}}, 1'b1} << r_grant) : '0;
  assign bus.o_wr    = w_xfer;
  assign bus.o_data  = {w_sel_last, r_grant, w_sel_data};
  assign bus.o_busy  = w_burst;
  assign bus.o_grant = r_grant;

endmodule

`default_nettype wire
